// File: rtl/uart_response_buffer_if.sv
// UART-side byte streams of the response buffer: TX toward the transmitter,
// RX strobes from the receiver. master = buffer side, slave = UART side.
interface uart_response_buffer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/uart_response_buffer.sv
// Bridge between the IDE/GD-ROM command processor and the host UART link.
// Sends the snapshotted command packet on a start edge, packs response bytes
// little-endian into 16-bit words and exposes them on a combinational read port.
module uart_response_buffer #(
    parameter int ADDR_W    = 10,
    parameter int CMD_BYTES = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   uart_start,
    input  logic [CMD_BYTES*8-1:0] cmd_buf,
    input  logic                   reset_bytes_transmitted,
    input  logic [15:0]            read_addr,
    output logic [15:0]            word_in,
    output logic [15:0]            bytes_in,
    output logic                   tx_active,
    output logic                   rx_overrun,
    uart_response_buffer_if.master uart
);
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam int          IDX_W     = $clog2(CMD_BYTES + 1);
    localparam logic [16:0] OVR_LIMIT = 17'(2 * DEPTH);

    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t                state_q, state_d;
    logic [CMD_BYTES*8-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]         tx_idx_q, tx_idx_d;
    logic                     uart_start_q;
    logic                     start_edge;

    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic                     pending_q, pending_d;
    logic [7:0]               lo_byte_q, lo_byte_d;
    logic [15:0]              bytes_in_q, bytes_in_d;
    logic [16:0]              ovr_cnt_q, ovr_cnt_d;
    logic                     rx_overrun_q, rx_overrun_d;

    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [15:0]              mem_wdata;
    logic [15:0]              mem [DEPTH];

    // Upper read address bits are ignored; the buffer wraps at DEPTH words.
    logic                     unused_read_addr;
    assign unused_read_addr = ^read_addr[15:ADDR_W];

    assign start_edge    = uart_start & ~uart_start_q;
    assign uart.tx_valid = (state_q == SEND);
    assign tx_active     = (state_q == SEND);
    assign uart.tx_data  = snap_q[8*tx_idx_q +: 8];
    assign word_in       = mem[read_addr[ADDR_W-1:0]];
    assign bytes_in      = bytes_in_q;
    assign rx_overrun    = rx_overrun_q;

    // TX FSM: snapshot on start edge, then walk bytes on each accept.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        tx_idx_d = tx_idx_q;
        case (state_q)
            IDLE: if (start_edge) begin
                snap_d   = cmd_buf;
                tx_idx_d = '0;
                state_d  = SEND;
            end
            SEND: if (uart.tx_ready) begin
                if (tx_idx_q == IDX_W'(CMD_BYTES - 1)) state_d = IDLE;
                else                                   tx_idx_d = tx_idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // RX packing: a clear flushes any half word first, then a same-cycle
    // byte starts a fresh word as byte 0. At most one memory write per cycle.
    always_comb begin
        logic        pend_now;
        logic [15:0] bytes_base;
        logic [16:0] ovr_base;
        wr_addr_d    = wr_addr_q;
        pending_d    = pending_q;
        lo_byte_d    = lo_byte_q;
        bytes_in_d   = bytes_in_q;
        ovr_cnt_d    = ovr_cnt_q;
        rx_overrun_d = rx_overrun_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr_q;
        mem_wdata    = {8'h00, lo_byte_q};
        pend_now     = pending_q;
        bytes_base   = bytes_in_q;
        ovr_base     = ovr_cnt_q;

        if (reset_bytes_transmitted) begin
            bytes_base   = '0;
            ovr_base     = '0;
            bytes_in_d   = '0;
            ovr_cnt_d    = '0;
            rx_overrun_d = 1'b0;
            pend_now     = 1'b0;
            if (pending_q) begin
                mem_we    = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                pending_d = 1'b0;
            end
        end

        if (uart.rx_valid) begin
            if (!pend_now) begin
                lo_byte_d = uart.rx_data;
                pending_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_wdata = {uart.rx_data, lo_byte_q};
                wr_addr_d = wr_addr_q + 1'b1;
                pending_d = 1'b0;
            end
            bytes_in_d = (bytes_base == 16'hFFFF) ? bytes_base : bytes_base + 16'd1;
            // Counter stops just past the limit so it can never wrap back under.
            ovr_cnt_d  = (ovr_base > OVR_LIMIT) ? ovr_base : ovr_base + 17'd1;
            if (ovr_cnt_d > OVR_LIMIT) rx_overrun_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset; data holders unreset.
    always_ff @(posedge clk) begin
        snap_q    <= snap_d;
        lo_byte_q <= lo_byte_d;
        if (!reset_n) begin
            state_q      <= IDLE;
            tx_idx_q     <= '0;
            uart_start_q <= 1'b0;
            wr_addr_q    <= '0;
            pending_q    <= 1'b0;
            bytes_in_q   <= '0;
            ovr_cnt_q    <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_idx_q     <= tx_idx_d;
            uart_start_q <= uart_start;
            wr_addr_q    <= wr_addr_d;
            pending_q    <= pending_d;
            bytes_in_q   <= bytes_in_d;
            ovr_cnt_q    <= ovr_cnt_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    // Response buffer: contents survive reset, writes suppressed while in reset.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_uart_response_buffer.sv
module tb_uart_response_buffer;
    logic        clk = 1'b0;
    logic        rst1_n, rst2_n;
    logic        start1;
    logic [95:0] cmd1;
    logic        clr1, clr2;
    logic [15:0] ra1, ra2;
    logic [15:0] wi1, wi2, bi1, bi2;
    logic        act1, act2, ovr1, ovr2;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  got [16];
    int          ngot;

    uart_response_buffer_if u1 ();
    uart_response_buffer_if u2 ();

    uart_response_buffer #(.ADDR_W(10), .CMD_BYTES(12)) dut (
        .clk(clk), .reset_n(rst1_n), .uart_start(start1), .cmd_buf(cmd1),
        .reset_bytes_transmitted(clr1), .read_addr(ra1), .word_in(wi1),
        .bytes_in(bi1), .tx_active(act1), .rx_overrun(ovr1), .uart(u1.master));

    uart_response_buffer #(.ADDR_W(2), .CMD_BYTES(12)) dut2 (
        .clk(clk), .reset_n(rst2_n), .uart_start(1'b0), .cmd_buf(96'h0),
        .reset_bytes_transmitted(clr2), .read_addr(ra2), .word_in(wi2),
        .bytes_in(bi2), .tx_active(act2), .rx_overrun(ovr2), .uart(u2.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] pkt(input logic [7:0] b0, input logic [7:0] base);
        logic [95:0] c;
        for (int k = 0; k < 12; k++) c[8*k +: 8] = (k == 0) ? b0 : base + 8'(k);
        return c;
    endfunction

    // Drive one rx byte (optionally with clear) for one cycle on selected DUT.
    task automatic send_rx(input int sel, input logic [7:0] b, input logic clr);
        if (sel == 1) begin u1.rx_valid = 1'b1; u1.rx_data = b; clr1 = clr; end
        else          begin u2.rx_valid = 1'b1; u2.rx_data = b; clr2 = clr; end
        @(negedge clk);
        u1.rx_valid = 1'b0; u2.rx_valid = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic pulse_clr(input int sel);
        if (sel == 1) clr1 = 1'b1; else clr2 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0; clr2 = 1'b0;
    endtask

    // Collect accepted tx bytes over a bounded window. In slow mode ready is
    // 1-on/2-off, cmd_buf is changed and a second start edge is issued mid-packet.
    task automatic collect(input int ncyc, input bit slow);
        ngot = 0;
        for (int i = 0; i < 16; i++) got[i] = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            u1.tx_ready = slow ? (c % 3 == 0) : 1'b1;
            if (slow && c == 4) begin cmd1 = {12{8'h5A}}; start1 = 1'b0; end
            if (slow && c == 7) start1 = 1'b1;
            #1;
            if (u1.tx_valid && u1.tx_ready) begin
                if (ngot < 16) got[ngot] = u1.tx_data;
                ngot++;
            end
        end
    endtask

    initial begin
        logic [95:0] exp_a, exp_b;
        exp_a = pkt(8'h70, 8'h00);
        exp_b = pkt(8'hA0, 8'hA0);
        rst1_n = 1'b0; rst2_n = 1'b0; start1 = 1'b0; cmd1 = exp_a;
        clr1 = 1'b0; clr2 = 1'b0; ra1 = '0; ra2 = '0;
        u1.tx_ready = 1'b1; u1.rx_valid = 1'b0; u1.rx_data = '0;
        u2.tx_ready = 1'b1; u2.rx_valid = 1'b0; u2.rx_data = '0;
        repeat (3) @(negedge clk);
        rst1_n = 1'b1; rst2_n = 1'b1;

        chk("rst_tx_valid", u1.tx_valid, 0);
        chk("rst_tx_active", act1, 0);
        chk("rst_bytes_in", bi1, 0);
        chk("rst_overrun", ovr1, 0);

        // Back-to-back packet with ready tied high.
        start1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("p1_valid%0d", i), u1.tx_valid, 1);
            chk($sformatf("p1_active%0d", i), act1, 1);
            chk($sformatf("p1_data%0d", i), u1.tx_data, exp_a[8*i +: 8]);
        end
        @(negedge clk);
        chk("p1_done_valid", u1.tx_valid, 0);
        chk("p1_done_active", act1, 0);
        start1 = 1'b0;
        @(negedge clk);

        // Throttled packet, snapshot must hold, restart ignored.
        cmd1 = exp_b; start1 = 1'b1; u1.tx_ready = 1'b0;
        collect(60, 1'b1);
        chk("p2_count", ngot, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("p2_byte%0d", i), got[i], exp_b[8*i +: 8]);
        chk("p2_idle", u1.tx_valid, 0);
        start1 = 1'b0; u1.tx_ready = 1'b1;

        // Little-endian packing from wr_addr 0.
        send_rx(1, 8'h34, 0); send_rx(1, 8'h12, 0);
        send_rx(1, 8'h78, 0); send_rx(1, 8'h56, 0);
        ra1 = 16'd0; #1 chk("rx_mem0", wi1, 16'h1234);
        ra1 = 16'd1; #1 chk("rx_mem1", wi1, 16'h5678);
        chk("rx_bytes4", bi1, 4);

        // Odd count then clear flushes 00CC; clear+byte starts fresh word.
        send_rx(1, 8'hAA, 0); send_rx(1, 8'hBB, 0); send_rx(1, 8'hCC, 0);
        chk("rx_bytes7", bi1, 7);
        pulse_clr(1);
        chk("clr_bytes0", bi1, 0);
        ra1 = 16'd2; #1 chk("rx_mem2", wi1, 16'hBBAA);
        ra1 = 16'd3; #1 chk("flush_mem3", wi1, 16'h00CC);
        send_rx(1, 8'hDD, 1);
        chk("clr_rx_bytes1", bi1, 1);
        send_rx(1, 8'hEE, 0);
        ra1 = 16'd4; #1 chk("clr_rx_mem4", wi1, 16'hEEDD);
        chk("clr_rx_bytes2", bi1, 2);
        // Pending byte flushed in the same cycle a new byte arrives.
        send_rx(1, 8'hFF, 0);
        send_rx(1, 8'h11, 1);
        chk("flush_rx_bytes1", bi1, 1);
        ra1 = 16'd5; #1 chk("flush_rx_mem5", wi1, 16'h00FF);
        send_rx(1, 8'h22, 0);
        ra1 = 16'd6; #1 chk("flush_rx_mem6", wi1, 16'h2211);
        ra1 = 16'h0406; #1 chk("addr_high_ignored", wi1, 16'h2211);

        // Wrap and overrun on the ADDR_W=2 instance, starting at wr_addr 3.
        for (int i = 0; i < 6; i++) send_rx(2, 8'h00, 0);
        pulse_clr(2);
        for (int i = 0; i < 9; i++) begin
            send_rx(2, 8'h10 + 8'(i), 0);
            if (i == 7) chk("ovr_at8", ovr2, 0);
        end
        chk("ovr_at9", ovr2, 1);
        ra2 = 16'd3;
        u2.rx_valid = 1'b1; u2.rx_data = 8'h19; #1;
        chk("same_cycle_old", wi2, 16'h1110);
        @(negedge clk);
        u2.rx_valid = 1'b0; #1;
        chk("wrap_mem3", wi2, 16'h1918);
        ra2 = 16'd0; #1 chk("wrap_mem0", wi2, 16'h1312);
        ra2 = 16'd1; #1 chk("wrap_mem1", wi2, 16'h1514);
        ra2 = 16'd2; #1 chk("wrap_mem2", wi2, 16'h1716);
        chk("wrap_bytes10", bi2, 10);
        chk("ovr_sticky", ovr2, 1);
        pulse_clr(2);
        chk("ovr_cleared", ovr2, 0);
        chk("ovr_bytes0", bi2, 0);

        // Reset mid-packet with a half word pending.
        send_rx(1, 8'h33, 0);
        cmd1 = exp_a; start1 = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        @(negedge clk);
        chk("mid_byte5", u1.tx_data, exp_a[47:40]);
        rst1_n = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", u1.tx_valid, 0);
        chk("mid_rst_bytes", bi1, 0);
        rst1_n = 1'b1;
        send_rx(1, 8'h44, 0); send_rx(1, 8'h55, 0);
        ra1 = 16'd0; #1 chk("post_rst_mem0", wi1, 16'h5544);
        chk("post_rst_bytes", bi1, 2);
        start1 = 1'b1;
        collect(20, 1'b0);
        chk("post_rst_count", ngot, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("post_rst_byte%0d", i), got[i], exp_a[8*i +: 8]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_response_buffer.md
Name: uart_response_buffer

Overview:
- Bridge between the IDE/GD-ROM command processor and the host UART link.
- On a start request it serialises the 12-byte SPI command packet to the UART transmitter.
- It collects the host's response bytes, packs them little-endian into 16-bit words in a local buffer, and reports the running byte count.
- It serves buffer words to the IDE processor through a combinational read port.

Parameters:
- ADDR_W, 10: word-address width; buffer depth DEPTH = 2^ADDR_W 16-bit words.
- CMD_BYTES, 12: number of command bytes sent per start request.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- uart_start  in  1  start request from IDE processor; level, rising edge significant
- cmd_buf  in  96  command packet; byte k = bits [8k+7:8k], k=0 sent first
- reset_bytes_transmitted  in  1  clears response byte count (single-cycle pulse)
- read_addr  in  16  word address from IDE processor; low ADDR_W bits used
- word_in  out  16  mem[read_addr[ADDR_W-1:0]], combinational
- bytes_in  out  16  response bytes received since last reset_bytes_transmitted
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_active  out  1  high while a command packet is being sent
- rx_overrun  out  1  sticky; more than 2*DEPTH bytes received since last clear

Behaviour:
- Synchronous reset (reset_n=0 at clk edge) sets:
  - tx_valid=0, tx_active=0, bytes_in=0, rx_overrun=0.
  - Write pointer wr_addr=0, half-word pending flag=0, start edge detector=0, TX FSM to IDLE.
  - Buffer contents are not cleared.
- Start detect: start_edge = uart_start & ~uart_start_q, where uart_start_q is registered each cycle.
- TX FSM:
  - IDLE: on start_edge, snapshot cmd_buf into an internal register, tx_idx=0, go to SEND. tx_valid=1 and tx_active=1 from the next cycle.
  - SEND: tx_data=snap byte tx_idx; tx_valid held high and tx_data stable until accepted.
    - On accept: if tx_idx==CMD_BYTES-1, go to IDLE with tx_valid=0 and tx_active=0 the next cycle; else tx_idx+1.
    - start_edge in SEND is ignored; the snapshot is unaffected by later cmd_buf changes.
  - With tx_ready tied high, the packet takes exactly CMD_BYTES cycles of tx_valid=1.
- RX path runs independently of the TX FSM and is active in all states.
  - rx_valid with pending=0: lo_byte<=rx_data, pending<=1.
  - rx_valid with pending=1: mem[wr_addr]<={rx_data, lo_byte}, wr_addr<=wr_addr+1 (wraps modulo DEPTH), pending<=0.
  - Each rx_valid increments bytes_in, saturating at 16'hFFFF.
  - An internal 17-bit byte counter sets rx_overrun when it exceeds 2*DEPTH.
- reset_bytes_transmitted:
  - Clears bytes_in, the overrun counter and rx_overrun.
  - If pending=1, the pending byte is flushed as {8'h00, lo_byte} to mem[wr_addr] and wr_addr advances.
  - wr_addr is NOT reset, so it stays aligned with the consumer's free-running read_addr.
- Simultaneous reset_bytes_transmitted and rx_valid:
  - The clear/flush happens first, then the new byte is treated as byte 0: bytes_in=1, pending=1, lo_byte=rx_data.
  - If a flush occurred, the write targets the old wr_addr and the new byte belongs to wr_addr+1.
- Read port:
  - word_in reflects a write on the cycle after the write edge.
  - Read and write to the same address in the same cycle returns the old data.
- Mid-operation reset_n abandons the packet immediately: tx_valid drops on the next cycle and the partial word is discarded.

Test Plan:
- tx_ready=1, cmd_buf bytes 0x70,0x01..0x0B, uart_start 0->1 -> tx_data sequence 0x70,0x01..0x0B over 12 consecutive cycles; tx_active high 12 cycles; then tx_valid=0.
- tx_ready toggled 1 cycle on / 2 cycles off, cmd_buf changed after start -> original 12 bytes in order, no duplicates or drops; second uart_start edge during SEND produces no extra bytes.
- rx bytes 0x34,0x12,0x78,0x56 from wr_addr=0 -> mem[0]=0x1234, mem[1]=0x5678, bytes_in=4; word_in=0x5678 when read_addr=1.
- 3 rx bytes 0xAA,0xBB,0xCC, then reset_bytes_transmitted -> mem[1]=0x00CC, wr_addr=2, bytes_in=0; next byte 0xDD with reset_bytes_transmitted in the same cycle -> bytes_in=1, later partner byte 0xEE writes mem[2]=0xEEDD.
- ADDR_W=2, 10 rx bytes from wr_addr=3 -> writes wrap to addresses 3,0,1,2,3; rx_overrun=1 after byte 9; reset_bytes_transmitted clears it.
- reset_n=0 mid-packet after 5 bytes sent -> tx_valid=0 next cycle, bytes_in=0, wr_addr=0; a new uart_start edge sends a full 12 bytes.
